// File: rtl/y86_decode_stage_pkg.sv
// Shared Y86-64 definitions for the decode slice: instruction codes,
// special register IDs, status codes and the D->E pipeline register layout.
package y86_decode_stage_pkg;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,   // also conditional moves
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   localparam logic [3:0] REG_RSP  = 4'h4;
   localparam logic [3:0] REG_NONE = 4'hF;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] pc;
      logic [63:0] valc;
      logic [63:0] vala;
      logic [63:0] valb;
      logic [3:0]  dste;
      logic [3:0]  dstm;
      logic [3:0]  srca;
      logic [3:0]  srcb;
      logic        branch_taken;
   } e_reg_t;

   // Contents of the E register when it holds a bubble.
   function automatic e_reg_t e_nop();
      e_reg_t r;
      r              = '0;
      r.stat         = STAT_AOK;
      r.icode        = I_NOP;
      r.dste         = REG_NONE;
      r.dstm         = REG_NONE;
      r.srca         = REG_NONE;
      r.srcb         = REG_NONE;
      return r;
   endfunction

endpackage

// File: rtl/y86_decode_stage_if.sv
// Bundle of every non-clock signal of the decode slice.
// master: upstream/downstream pipeline (drives D/F/forwarding inputs,
//         receives E register and decode sources).
// slave : the decode stage itself.
interface y86_decode_stage_if;
   logic        F_stall_i, F_bubble_i;
   logic [63:0] f_predPC_i;
   logic [63:0] F_predPC_o;

   logic [63:0] D_PC_i, D_valC_i, D_valP_i;
   logic [2:0]  D_stat_i;
   logic [3:0]  D_icode_i, D_ifun_i, D_rA_i, D_rB_i;
   logic        D_branch_taken_i;

   logic [3:0]  e_dstE_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i;
   logic [63:0] e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i;

   logic        E_stall_i, E_bubble_i;

   logic [3:0]  d_srcA_o, d_srcB_o;
   logic [63:0] E_PC_o, E_valC_o, E_valA_o, E_valB_o;
   logic [2:0]  E_stat_o;
   logic [3:0]  E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o;
   logic        E_branch_taken_o;

   modport master (
      output F_stall_i, F_bubble_i, f_predPC_i,
      output D_PC_i, D_valC_i, D_valP_i, D_stat_i,
      output D_icode_i, D_ifun_i, D_rA_i, D_rB_i, D_branch_taken_i,
      output e_dstE_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i,
      output e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i,
      output E_stall_i, E_bubble_i,
      input  F_predPC_o, d_srcA_o, d_srcB_o,
      input  E_PC_o, E_valC_o, E_valA_o, E_valB_o, E_stat_o,
      input  E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o,
      input  E_branch_taken_o
   );

   modport slave (
      input  F_stall_i, F_bubble_i, f_predPC_i,
      input  D_PC_i, D_valC_i, D_valP_i, D_stat_i,
      input  D_icode_i, D_ifun_i, D_rA_i, D_rB_i, D_branch_taken_i,
      input  e_dstE_i, M_dstE_i, M_dstM_i, W_dstE_i, W_dstM_i,
      input  e_valE_i, M_valE_i, m_valM_i, W_valE_i, W_valM_i,
      input  E_stall_i, E_bubble_i,
      output F_predPC_o, d_srcA_o, d_srcB_o,
      output E_PC_o, E_valC_o, E_valA_o, E_valB_o, E_stat_o,
      output E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o,
      output E_branch_taken_o
   );
endinterface

// File: rtl/y86_decode_stage_regfile.sv
// y86_regfile: 15 x 64-bit register file, two combinational read ports and
// two write ports (E and M). Register ID F reads as 0 and is never written.
// Ports: clk_i/rst_n_i (async active-low clear), srcA_i/srcB_i -> valA_o/valB_o,
//        dstE_i/valE_i and dstM_i/valM_i write ports.
module y86_regfile
   import y86_decode_stage_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [3:0]  srcA_i,
   input  logic [3:0]  srcB_i,
   output logic [63:0] valA_o,
   output logic [63:0] valB_o,
   input  logic [3:0]  dstE_i,
   input  logic [63:0] valE_i,
   input  logic [3:0]  dstM_i,
   input  logic [63:0] valM_i
);

   logic [63:0] regs_q [15];

   // M port is written last so a load wins over an ALU result to the same ID.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < 15; i++) regs_q[i] <= '0;
      end else begin
         if (dstE_i != REG_NONE) regs_q[dstE_i] <= valE_i;
         if (dstM_i != REG_NONE) regs_q[dstM_i] <= valM_i;
      end
   end

   assign valA_o = (srcA_i == REG_NONE) ? '0 : regs_q[srcA_i];
   assign valB_o = (srcB_i == REG_NONE) ? '0 : regs_q[srcB_i];

endmodule

// File: rtl/y86_decode_stage.sv
// y86_decode_stage: F predicted-PC register, decode (source/destination
// selection, register file, forwarding) and the D->E pipeline register.
// Ports: clk_i, rst_n_i (async active-low), bus (y86_decode_stage_if.slave)
//        carrying F/D inputs, forwarding sources, E stall/bubble, the E
//        register fields and d_srcA/d_srcB for external hazard control.
module y86_decode_stage
   import y86_decode_stage_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_n_i,
   y86_decode_stage_if.slave bus
);

   icode_e      d_icode;
   logic [3:0]  d_srca, d_srcb, d_dste, d_dstm;
   logic [63:0] rf_vala, rf_valb, d_vala, d_valb;
   logic [63:0] f_pred_d, f_pred_q;
   e_reg_t      e_d, e_q;

   assign d_icode = icode_e'(bus.D_icode_i);

   always_comb begin
      d_srca = REG_NONE;
      d_srcb = REG_NONE;
      d_dste = REG_NONE;
      d_dstm = REG_NONE;
      case (d_icode)
         I_RRMOVQ: begin d_srca = bus.D_rA_i; d_dste = bus.D_rB_i; end
         I_IRMOVQ: d_dste = bus.D_rB_i;
         I_RMMOVQ: begin d_srca = bus.D_rA_i; d_srcb = bus.D_rB_i; end
         I_MRMOVQ: begin d_srcb = bus.D_rB_i; d_dstm = bus.D_rA_i; end
         I_OPQ: begin
            d_srca = bus.D_rA_i;
            d_srcb = bus.D_rB_i;
            d_dste = bus.D_rB_i;
         end
         I_CALL: begin d_srcb = REG_RSP; d_dste = REG_RSP; end
         I_RET: begin
            d_srca = REG_RSP;
            d_srcb = REG_RSP;
            d_dste = REG_RSP;
         end
         I_PUSHQ: begin
            d_srca = bus.D_rA_i;
            d_srcb = REG_RSP;
            d_dste = REG_RSP;
         end
         I_POPQ: begin
            d_srca = REG_RSP;
            d_srcb = REG_RSP;
            d_dste = REG_RSP;
            d_dstm = bus.D_rA_i;
         end
         default: ;
      endcase
   end

   y86_regfile u_regfile (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .srcA_i  (d_srca),
      .srcB_i  (d_srcb),
      .valA_o  (rf_vala),
      .valB_o  (rf_valb),
      .dstE_i  (bus.W_dstE_i),
      .valE_i  (bus.W_valE_i),
      .dstM_i  (bus.W_dstM_i),
      .valM_i  (bus.W_valM_i)
   );

   // Youngest producer wins; an F source never matches a forwarding tag.
   always_comb begin
      d_vala = rf_vala;
      if (d_icode == I_JXX || d_icode == I_CALL)                  d_vala = bus.D_valP_i;
      else if (d_srca == REG_NONE)                                d_vala = rf_vala;
      else if (d_srca == bus.e_dstE_i)                            d_vala = bus.e_valE_i;
      else if (d_srca == bus.M_dstM_i)                            d_vala = bus.m_valM_i;
      else if (d_srca == bus.M_dstE_i)                            d_vala = bus.M_valE_i;
      else if (d_srca == bus.W_dstM_i)                            d_vala = bus.W_valM_i;
      else if (d_srca == bus.W_dstE_i)                            d_vala = bus.W_valE_i;
   end

   always_comb begin
      d_valb = rf_valb;
      if (d_srcb == REG_NONE)                                     d_valb = rf_valb;
      else if (d_srcb == bus.e_dstE_i)                            d_valb = bus.e_valE_i;
      else if (d_srcb == bus.M_dstM_i)                            d_valb = bus.m_valM_i;
      else if (d_srcb == bus.M_dstE_i)                            d_valb = bus.M_valE_i;
      else if (d_srcb == bus.W_dstM_i)                            d_valb = bus.W_valM_i;
      else if (d_srcb == bus.W_dstE_i)                            d_valb = bus.W_valE_i;
   end

   always_comb begin
      f_pred_d = f_pred_q;
      if (bus.F_bubble_i)     f_pred_d = '0;
      else if (!bus.F_stall_i) f_pred_d = bus.f_predPC_i;
   end

   // Bubble takes precedence over stall.
   always_comb begin
      e_d = e_q;
      if (bus.E_bubble_i) begin
         e_d = e_nop();
      end else if (!bus.E_stall_i) begin
         e_d.stat         = bus.D_stat_i;
         e_d.icode        = bus.D_icode_i;
         e_d.ifun         = bus.D_ifun_i;
         e_d.pc           = bus.D_PC_i;
         e_d.valc         = bus.D_valC_i;
         e_d.vala         = d_vala;
         e_d.valb         = d_valb;
         e_d.dste         = d_dste;
         e_d.dstm         = d_dstm;
         e_d.srca         = d_srca;
         e_d.srcb         = d_srcb;
         e_d.branch_taken = bus.D_branch_taken_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         f_pred_q <= '0;
         e_q      <= e_nop();
      end else begin
         f_pred_q <= f_pred_d;
         e_q      <= e_d;
      end
   end

   assign bus.F_predPC_o       = f_pred_q;
   assign bus.d_srcA_o         = d_srca;
   assign bus.d_srcB_o         = d_srcb;
   assign bus.E_stat_o         = e_q.stat;
   assign bus.E_icode_o        = e_q.icode;
   assign bus.E_ifun_o         = e_q.ifun;
   assign bus.E_PC_o           = e_q.pc;
   assign bus.E_valC_o         = e_q.valc;
   assign bus.E_valA_o         = e_q.vala;
   assign bus.E_valB_o         = e_q.valb;
   assign bus.E_dstE_o         = e_q.dste;
   assign bus.E_dstM_o         = e_q.dstm;
   assign bus.E_srcA_o         = e_q.srca;
   assign bus.E_srcB_o         = e_q.srcb;
   assign bus.E_branch_taken_o = e_q.branch_taken;

endmodule

// File: tb/tb_y86_decode_stage.sv
// Self-checking bench for y86_decode_stage: directed scenarios plus a
// randomized run against a behavioural pipeline model.
module tb_y86_decode_stage;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode, ifun, dstE, dstM, srcA, srcB;
      logic        bt;
      logic [63:0] pc, valC, valA, valB;
   } exp_e_t;

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   y86_decode_stage_if bus ();

   y86_decode_stage dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus)
   );

   always #5 clk_i = ~clk_i;

   // Reference state
   logic [63:0] mregs [15];
   exp_e_t      exp_E;
   logic [63:0] exp_F;

   function automatic exp_e_t nop_model();
      exp_e_t r;
      r = '0;
      r.stat = 3'd1; r.icode = 4'd1;
      r.dstE = 4'hF; r.dstM = 4'hF; r.srcA = 4'hF; r.srcB = 4'hF;
      return r;
   endfunction

   function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [63:0] m_read(input logic [3:0] s);
      if (s == 4'hF) return 64'd0;
      if (s == bus.e_dstE_i) return bus.e_valE_i;
      if (s == bus.M_dstM_i) return bus.m_valM_i;
      if (s == bus.M_dstE_i) return bus.M_valE_i;
      if (s == bus.W_dstM_i) return bus.W_valM_i;
      if (s == bus.W_dstE_i) return bus.W_valE_i;
      return mregs[s];
   endfunction

   function automatic exp_e_t m_decode();
      exp_e_t r;
      logic [3:0] ic;
      ic     = bus.D_icode_i;
      r.stat = bus.D_stat_i; r.icode = ic; r.ifun = bus.D_ifun_i;
      r.bt   = bus.D_branch_taken_i;
      r.pc   = bus.D_PC_i; r.valC = bus.D_valC_i;
      r.srcA = m_srcA(ic, bus.D_rA_i);
      r.srcB = m_srcB(ic, bus.D_rB_i);
      r.dstE = (ic inside {4'h2, 4'h3, 4'h6}) ? bus.D_rB_i :
               (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
      r.dstM = (ic inside {4'h5, 4'hB}) ? bus.D_rA_i : 4'hF;
      r.valA = (ic inside {4'h7, 4'h8}) ? bus.D_valP_i : m_read(r.srcA);
      r.valB = m_read(r.srcB);
      return r;
   endfunction

   function automatic exp_e_t actual_e();
      exp_e_t r;
      r.stat = bus.E_stat_o; r.icode = bus.E_icode_o; r.ifun = bus.E_ifun_o;
      r.dstE = bus.E_dstE_o; r.dstM = bus.E_dstM_o;
      r.srcA = bus.E_srcA_o; r.srcB = bus.E_srcB_o;
      r.bt   = bus.E_branch_taken_o;
      r.pc   = bus.E_PC_o; r.valC = bus.E_valC_o;
      r.valA = bus.E_valA_o; r.valB = bus.E_valB_o;
      return r;
   endfunction

   // Advance one clock and step the model; no checking here.
   task automatic cycle();
      exp_e_t nxt;
      logic [63:0] nf, ve, vm;
      logic [3:0]  de, dm;
      nxt = bus.E_bubble_i ? nop_model() : (bus.E_stall_i ? exp_E : m_decode());
      nf  = bus.F_bubble_i ? 64'd0 : (bus.F_stall_i ? exp_F : bus.f_predPC_i);
      de = bus.W_dstE_i; ve = bus.W_valE_i; dm = bus.W_dstM_i; vm = bus.W_valM_i;
      @(posedge clk_i);
      #1;
      exp_E = nxt;
      exp_F = nf;
      if (de != 4'hF) mregs[de] = ve;
      if (dm != 4'hF) mregs[dm] = vm;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 15; i++) mregs[i] = 64'd0;
      exp_E = nop_model();
      exp_F = 64'd0;
   endtask

   task automatic set_idle();
      bus.F_stall_i = 0; bus.F_bubble_i = 0;
      bus.D_PC_i = 0; bus.D_valC_i = 0; bus.D_valP_i = 0;
      bus.D_stat_i = 3'd1; bus.D_icode_i = 4'h1; bus.D_ifun_i = 0;
      bus.D_rA_i = 4'hF; bus.D_rB_i = 4'hF; bus.D_branch_taken_i = 0;
      bus.e_dstE_i = 4'hF; bus.M_dstE_i = 4'hF; bus.M_dstM_i = 4'hF;
      bus.W_dstE_i = 4'hF; bus.W_dstM_i = 4'hF;
      bus.e_valE_i = 0; bus.M_valE_i = 0; bus.m_valM_i = 0;
      bus.W_valE_i = 0; bus.W_valM_i = 0;
      bus.E_stall_i = 0; bus.E_bubble_i = 0;
   endtask

   task automatic test_reset();
      set_idle();
      bus.f_predPC_i = 64'h1234;
      rst_n_i = 0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++;
      if (bus.F_predPC_o !== 64'd0) begin
         n_fail++; $display("FAIL reset_F: got %h want 0", bus.F_predPC_o);
      end
      n_checks++;
      if (bus.E_icode_o !== 4'h1 || bus.E_dstE_o !== 4'hF || bus.E_stat_o !== 3'd1) begin
         n_fail++;
         $display("FAIL reset_E: icode %h dstE %h stat %h want 1/F/1",
                  bus.E_icode_o, bus.E_dstE_o, bus.E_stat_o);
      end
      rst_n_i = 1;
      bus.f_predPC_i = 64'h14;
      cycle();
      n_checks++;
      if (bus.F_predPC_o !== 64'h14) begin
         n_fail++; $display("FAIL f_load: got %h want 14", bus.F_predPC_o);
      end
      for (int r = 0; r < 15; r++) begin
         bus.D_icode_i = 4'h6; bus.D_rA_i = 4'(r); bus.D_rB_i = 4'(r);
         cycle();
         n_checks++;
         if (bus.E_valA_o !== 64'd0 || bus.E_valB_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_reg%0d: valA %h valB %h want 0", r, bus.E_valA_o, bus.E_valB_o);
         end
      end
      set_idle();
   endtask

   task automatic test_writeback();
      set_idle();
      bus.W_dstE_i = 4'd3; bus.W_valE_i = 64'h55;
      cycle();
      set_idle();
      bus.D_icode_i = 4'h6; bus.D_rA_i = 4'd3; bus.D_rB_i = 4'd3;
      cycle();
      n_checks++;
      if (bus.E_valA_o !== 64'h55 || bus.E_valB_o !== 64'h55 || bus.E_dstE_o !== 4'd3) begin
         n_fail++;
         $display("FAIL writeback: valA %h valB %h dstE %h want 55/55/3",
                  bus.E_valA_o, bus.E_valB_o, bus.E_dstE_o);
      end
      set_idle();
   endtask

   task automatic test_forward_priority();
      set_idle();
      bus.D_icode_i = 4'h6; bus.D_rA_i = 4'd2; bus.D_rB_i = 4'd2;
      bus.e_dstE_i = 4'd2; bus.e_valE_i = 64'hAA;
      bus.M_dstE_i = 4'd2; bus.M_valE_i = 64'hBB;
      bus.W_dstE_i = 4'd2; bus.W_valE_i = 64'hCC;
      #1;
      n_checks++;
      if (bus.d_srcA_o !== 4'd2 || bus.d_srcB_o !== 4'd2) begin
         n_fail++; $display("FAIL d_src: %h/%h want 2/2", bus.d_srcA_o, bus.d_srcB_o);
      end
      cycle();
      n_checks++;
      if (bus.E_valA_o !== 64'hAA) begin
         n_fail++; $display("FAIL fwd_e: got %h want AA", bus.E_valA_o);
      end
      bus.e_dstE_i = 4'hF;
      cycle();
      n_checks++;
      if (bus.E_valA_o !== 64'hBB) begin
         n_fail++; $display("FAIL fwd_M: got %h want BB", bus.E_valA_o);
      end
      bus.M_dstE_i = 4'hF; bus.W_valE_i = 64'hDD;
      cycle();
      n_checks++;
      if (bus.E_valA_o !== 64'hDD) begin
         n_fail++; $display("FAIL fwd_W: got %h want DD", bus.E_valA_o);
      end
      bus.W_dstE_i = 4'hF;
      cycle();
      n_checks++;
      if (bus.E_valA_o !== 64'hDD || bus.E_valB_o !== 64'hDD) begin
         n_fail++; $display("FAIL rf_read: got %h/%h want DD/DD", bus.E_valA_o, bus.E_valB_o);
      end
      set_idle();
   endtask

   task automatic test_call_pop();
      set_idle();
      bus.D_icode_i = 4'h8; bus.D_valP_i = 64'h40;
      cycle();
      n_checks++;
      if (bus.E_valA_o !== 64'h40 || bus.E_srcB_o !== 4'd4 || bus.E_dstE_o !== 4'd4
          || bus.E_srcA_o !== 4'hF) begin
         n_fail++;
         $display("FAIL call: valA %h srcB %h dstE %h srcA %h want 40/4/4/F",
                  bus.E_valA_o, bus.E_srcB_o, bus.E_dstE_o, bus.E_srcA_o);
      end
      set_idle();
      bus.D_icode_i = 4'hB; bus.D_rA_i = 4'd1;
      cycle();
      n_checks++;
      if (bus.E_dstM_o !== 4'd1 || bus.E_srcA_o !== 4'd4 || bus.E_srcB_o !== 4'd4
          || bus.E_dstE_o !== 4'd4) begin
         n_fail++;
         $display("FAIL popq: dstM %h srcA %h srcB %h dstE %h want 1/4/4/4",
                  bus.E_dstM_o, bus.E_srcA_o, bus.E_srcB_o, bus.E_dstE_o);
      end
   endtask

   task automatic test_stall_bubble();
      set_idle();
      bus.D_icode_i = 4'h3; bus.D_rB_i = 4'd6; bus.D_valC_i = 64'h99;
      bus.E_stall_i = 1;
      cycle();
      n_checks++;
      if (bus.E_icode_o !== 4'hB || bus.E_dstM_o !== 4'd1 || bus.E_valC_o !== 64'd0) begin
         n_fail++;
         $display("FAIL e_stall: icode %h dstM %h valC %h want B/1/0",
                  bus.E_icode_o, bus.E_dstM_o, bus.E_valC_o);
      end
      bus.E_bubble_i = 1;
      cycle();
      n_checks++;
      if (bus.E_icode_o !== 4'h1 || bus.E_dstE_o !== 4'hF || bus.E_dstM_o !== 4'hF
          || bus.E_valC_o !== 64'd0) begin
         n_fail++;
         $display("FAIL e_bubble: icode %h dstE %h dstM %h want 1/F/F",
                  bus.E_icode_o, bus.E_dstE_o, bus.E_dstM_o);
      end
      set_idle();
      bus.f_predPC_i = 64'h100;
      cycle();
      bus.F_stall_i = 1; bus.f_predPC_i = 64'h200;
      cycle();
      n_checks++;
      if (bus.F_predPC_o !== 64'h100) begin
         n_fail++; $display("FAIL f_stall: got %h want 100", bus.F_predPC_o);
      end
      bus.F_bubble_i = 1;
      cycle();
      n_checks++;
      if (bus.F_predPC_o !== 64'd0) begin
         n_fail++; $display("FAIL f_bubble: got %h want 0", bus.F_predPC_o);
      end
      set_idle();
   endtask

   task automatic test_dual_write();
      set_idle();
      bus.W_dstE_i = 4'd5; bus.W_valE_i = 64'd1;
      bus.W_dstM_i = 4'd5; bus.W_valM_i = 64'd2;
      cycle();
      set_idle();
      bus.D_icode_i = 4'h6; bus.D_rA_i = 4'd5; bus.D_rB_i = 4'd5;
      cycle();
      n_checks++;
      if (bus.E_valA_o !== 64'd2 || bus.E_valB_o !== 64'd2) begin
         n_fail++;
         $display("FAIL dual_write: got %h/%h want 2/2", bus.E_valA_o, bus.E_valB_o);
      end
      set_idle();
   endtask

   task automatic test_midrun_reset();
      set_idle();
      bus.W_dstE_i = 4'd7; bus.W_valE_i = 64'h77;
      bus.D_icode_i = 4'h6; bus.D_rA_i = 4'd1; bus.D_rB_i = 4'd2;
      bus.f_predPC_i = 64'h300;
      cycle();
      #2;
      rst_n_i = 0;
      model_reset();
      #1;
      n_checks++;
      if (bus.F_predPC_o !== 64'd0 || bus.E_icode_o !== 4'h1 || bus.E_srcA_o !== 4'hF) begin
         n_fail++;
         $display("FAIL async_reset: F %h icode %h srcA %h want 0/1/F",
                  bus.F_predPC_o, bus.E_icode_o, bus.E_srcA_o);
      end
      rst_n_i = 1;
      set_idle();
      bus.D_icode_i = 4'h6; bus.D_rA_i = 4'd7; bus.D_rB_i = 4'd7;
      cycle();
      n_checks++;
      if (bus.E_valA_o !== 64'd0) begin
         n_fail++; $display("FAIL reset_clears_rf: got %h want 0", bus.E_valA_o);
      end
      set_idle();
   endtask

   task automatic test_random();
      exp_e_t got;
      for (int n = 0; n < 400; n++) begin
         bus.f_predPC_i = {$urandom, $urandom};
         bus.F_stall_i  = ($urandom_range(0, 7) == 0);
         bus.F_bubble_i = ($urandom_range(0, 9) == 0);
         bus.D_PC_i = {$urandom, $urandom}; bus.D_valC_i = {$urandom, $urandom};
         bus.D_valP_i = {$urandom, $urandom};
         bus.D_stat_i = 3'($urandom_range(0, 7));
         bus.D_icode_i = 4'($urandom_range(0, 15));
         bus.D_ifun_i = 4'($urandom_range(0, 15));
         bus.D_rA_i = 4'($urandom_range(0, 15)); bus.D_rB_i = 4'($urandom_range(0, 15));
         bus.D_branch_taken_i = 1'($urandom_range(0, 1));
         bus.e_dstE_i = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         bus.M_dstE_i = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         bus.M_dstM_i = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         bus.W_dstE_i = 4'($urandom_range(0, 15));
         bus.W_dstM_i = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         bus.e_valE_i = {$urandom, $urandom}; bus.M_valE_i = {$urandom, $urandom};
         bus.m_valM_i = {$urandom, $urandom}; bus.W_valE_i = {$urandom, $urandom};
         bus.W_valM_i = {$urandom, $urandom};
         bus.E_stall_i  = ($urandom_range(0, 7) == 0);
         bus.E_bubble_i = ($urandom_range(0, 9) == 0);
         #1;
         n_checks++;
         if (bus.d_srcA_o !== m_srcA(bus.D_icode_i, bus.D_rA_i)
             || bus.d_srcB_o !== m_srcB(bus.D_icode_i, bus.D_rB_i)) begin
            n_fail++;
            $display("FAIL rand_src[%0d]: got %h/%h want %h/%h", n, bus.d_srcA_o, bus.d_srcB_o,
                     m_srcA(bus.D_icode_i, bus.D_rA_i), m_srcB(bus.D_icode_i, bus.D_rB_i));
         end
         cycle();
         got = actual_e();
         n_checks++;
         if (got !== exp_E || bus.F_predPC_o !== exp_F) begin
            n_fail++;
            $display("FAIL rand_E[%0d]: got %h F %h want %h F %h", n, got, bus.F_predPC_o,
                     exp_E, exp_F);
         end
      end
      set_idle();
   endtask

   initial begin
      set_idle();
      bus.f_predPC_i = 0;
      test_reset();
      test_writeback();
      test_forward_priority();
      test_call_pop();
      test_stall_bubble();
      test_dual_write();
      test_midrun_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
